// File: rtl/muldiv8_seq_if.sv
// Handshake and result bus of the sequential 8-bit multiply/divide unit.
// Handshake: the requester raises start with op/a/b; the unit captures them
// on the rising edge only when it is not busy (IDLE or DONE), raises busy
// while iterating, and pulses done for one cycle when res_hi/res_lo/dbz
// become valid. Results then hold until the next completed operation.
interface muldiv8_seq_if;
    logic       start;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] res_hi;
    logic [7:0] res_lo;
    logic       dbz;

    modport master (
        output start, op, a, b,
        input  busy, done, res_hi, res_lo, dbz
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, res_hi, res_lo, dbz
    );
endinterface

// File: rtl/muldiv8_seq.sv
// Sequential 8-bit unsigned multiply (shift-add) / divide (restoring) unit.
// One pass through a shared 8-bit ripple add/sub per clock, eight passes
// per operation. Divide by zero finishes immediately with a flag.
module muldiv8_seq (
    input  logic              clk,
    input  logic              rst,
    muldiv8_seq_if.slave      bus,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  cnt;
    logic [7:0]  acc;
    logic [7:0]  q;
    logic [7:0]  bb;
    logic        mode;
    logic [7:0]  res_hi;
    logic [7:0]  res_lo;
    logic        dbz;

    logic        accept;
    logic        div_zero;
    logic        add_sub;
    logic [7:0]  add_x;
    logic [8:0]  add_out;
    logic [8:0]  r9;
    logic        div_ok;
    logic [7:0]  acc_nx;
    logic [7:0]  q_nx;

    // Ripple-carry adder/subtractor: sub inverts y and injects the carry, so
    // for subtraction a carry-out of 1 means no borrow.
    function automatic logic [8:0] walking_cra8(
        input logic [7:0] x,
        input logic [7:0] y,
        input logic       sub,
        input logic       cin
    );
        logic [7:0] yy;
        logic [7:0] s;
        logic       c;
        yy = y ^ {8{sub}};
        c  = cin ^ sub;
        for (int i = 0; i < 8; i++) begin
            s[i] = x[i] ^ yy[i] ^ c;
            c    = (x[i] & yy[i]) | (c & (x[i] ^ yy[i]));
        end
        return {c, s};
    endfunction

    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign div_zero = bus.op && (bus.b == 8'd0);

    // Shared datapath: one add (multiply) or trial subtract (divide) per cycle.
    always_comb begin
        r9      = {acc, q[7]};
        add_sub = mode;
        add_x   = mode ? r9[7:0] : acc;
        add_out = walking_cra8(add_x, bb, add_sub, 1'b0);
        div_ok  = r9[8] | add_out[8];
        acc_nx  = acc;
        q_nx    = q;
        if (mode) begin
            acc_nx = div_ok ? add_out[7:0] : r9[7:0];
            q_nx   = {q[6:0], div_ok};
        end else if (q[0]) begin
            acc_nx = add_out[8:1];
            q_nx   = {add_out[0], q[7:1]};
        end else begin
            acc_nx = {1'b0, acc[7:1]};
            q_nx   = {acc[0], q[7:1]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next-state: accept in IDLE/DONE, iterate eight times in RUN.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_nx = div_zero ? DONE : RUN;
                else        state_nx = IDLE;
            end
            RUN:     state_nx = (cnt == 3'd7) ? DONE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    // Working registers and result registers; results load only on DONE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 3'd0;
            acc    <= 8'd0;
            q      <= 8'd0;
            bb     <= 8'd0;
            mode   <= 1'b0;
            res_hi <= 8'd0;
            res_lo <= 8'd0;
            dbz    <= 1'b0;
        end else if (accept) begin
            cnt  <= 3'd0;
            acc  <= 8'd0;
            q    <= bus.a;
            bb   <= bus.b;
            mode <= bus.op;
            if (div_zero) begin
                res_hi <= bus.a;
                res_lo <= 8'hFF;
                dbz    <= 1'b1;
            end
        end else if (state == RUN) begin
            cnt <= cnt + 3'd1;
            acc <= acc_nx;
            q   <= q_nx;
            if (cnt == 3'd7) begin
                res_hi <= acc_nx;
                res_lo <= q_nx;
                dbz    <= 1'b0;
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.res_hi = res_hi;
    assign bus.res_lo = res_lo;
    assign bus.dbz    = dbz;
    assign dbg_state  = state;

endmodule

// File: doc/muldiv8_seq.md
# muldiv8_seq

Multi-cycle 8-bit unsigned multiply/divide unit that time-shares one 8-bit ripple add/sub datapath. The datapath is an instance of the team's walkingcra8. The unit runs one add or subtract iteration per clock under a small FSM and presents a start/busy/done handshake to the ALU result mux. Results are registered and held stable until the next accepted operation.

## Interface
- No parameters; width fixed at 8.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- op  in  1  0 = multiply, 1 = divide; captured with start.
- a  in  8  multiplicand / dividend; captured with start.
- b  in  8  multiplier / divisor; captured with start.
- busy  out  1  high while an operation is iterating.
- done  out  1  one-cycle pulse; results valid from this cycle.
- res_hi  out  8  multiply: product[15:8]; divide: remainder.
- res_lo  out  8  multiply: product[7:0]; divide: quotient.
- dbz  out  1  divide-by-zero flag of the last completed operation.

## Operation
- FSM states:
  - IDLE: start=1 captures op/a/b, clears iteration counter cnt (3 bit) and goes to RUN. Exception: op=1 with b=0 goes directly to DONE.
  - RUN: one iteration per cycle; after the iteration with cnt=7, goes to DONE.
  - DONE: lasts one cycle. start=1 here is accepted exactly as in IDLE, so back-to-back operations are allowed; otherwise goes to IDLE.
- Working registers are internal: acc[7:0], q[7:0], bb[7:0], mode. Outputs change only on entry to DONE.
- Multiply (shift-add):
  - Load: acc=0, q=a, bb=b.
  - Per iteration: if q[0]=1, {c,s} = acc + bb via the adder with sub=0, cin=0; else {c,s} = {0,acc}.
  - Then {acc,q} <= {c,s,q} >> 1, dropping the LSB.
  - After 8 iterations, {acc,q} = a*b (16-bit, never overflows).
- Divide (restoring):
  - Load: acc=0, q=a, bb=b.
  - Per iteration: r9 = {acc,q[7]} (9 bits).
  - Trial subtract r9[7:0] - bb on the adder with sub=1, cin=0.
  - Success when r9[8]=1 or no borrow, i.e. r9 >= bb. On success: acc <= diff[7:0], q <= {q[6:0],1}.
  - Otherwise: acc <= r9[7:0], q <= {q[6:0],0}.
  - Final: q = quotient, acc = remainder < b.
- Divide by zero: no iterations. res_lo=8'hFF, res_hi=a, dbz=1.
- dbz=0 for every other completed operation.
- start while busy=1 is ignored; inputs are not re-captured.
- op/a/b changes after the capture edge have no effect on the running operation.

## Timing
- Reset values: FSM=IDLE, busy=0, done=0, res_hi=0, res_lo=0, dbz=0, internal registers 0.
- rst asserted mid-operation abandons it immediately. No done pulse is generated, and outputs read 0.
- Edge E0 samples start=1 (normal case):
  - busy=1 during cycles E0+1 .. E0+8.
  - The edge at E0+8 performs the 8th iteration, enters DONE, and loads the results.
  - done=1 and busy=0 in the cycle following edge E0+8. Latency: 8 clocks from start edge to done.
- Divide by zero: done=1 in the cycle after E0 (latency 1); busy never asserts.
- Back-to-back: start=1 in the done cycle makes busy=1 in the next cycle. done falls that same cycle.
- res_hi/res_lo/dbz hold their values from the done cycle until the next DONE entry or reset.
- The adder operates combinationally within one cycle. The critical path is an 8-bit ripple carry plus a 2:1 mux into acc.

## Test plan
- Multiply 13 x 11: op=0, a=8'd13, b=8'd11. Expect res_hi=8'h00, res_lo=8'h8F, dbz=0, done exactly 8 cycles after the start edge, busy high for 8 cycles.
- Multiply 255 x 255: expect {res_hi,res_lo}=16'hFE01. Also 0 x 200 gives 16'h0000.
- Divide 200 / 7: op=1. Expect res_lo=8'd28, res_hi=8'd4. Also 255/1 gives res_lo=8'hFF, res_hi=0, and 5/9 gives res_lo=0, res_hi=5.
- Divide by zero, a=8'h5A, b=0:
  - done pulses 1 cycle after start; busy stays 0.
  - res_lo=8'hFF, res_hi=8'h5A, dbz=1.
  - A following 6x7 multiply clears dbz and gives 16'h002A.
- Handshake under disturbance:
  - start with 10x10; start re-asserted with other operands during busy (ignored) and operands changed mid-run. Expect 16'h0064.
  - start=1 during the done cycle with 100/10: the second op runs back-to-back and gives res_lo=8'd10, res_hi=0.
- Reset mid-operation: rst asserted at iteration 4 of 200x3. All outputs go to 0 asynchronously and no done pulse occurs. A new 200x3 after release gives 16'h0258.
